single_pe_module: RTL and testbench

- Single-processing-element 2D convolution engine: valid (no padding, stride 1) 3x3 cross-correlation of a 4x4 unsigned 8-bit matrix with a 3x3 kernel, producing a 2x2 result.
- One multiplier plus one accumulator, time-multiplexed over 36 multiply-accumulate (MAC) steps.
- Leaf compute block. Starts automatically when reset releases and raises done_single on completion.

---
 rtl/single_pe_module.sv | 120 ++++++++++++
 tb/tb_single_pe_module.sv | 132 +++++++++++++
 2 files changed

// File: rtl/single_pe_module.sv
// Single-PE 3x3 valid cross-correlation of a 4x4 unsigned matrix: one multiplier, one accumulator, 36 MAC steps.
// Optional macro CONV_SAT_EN: saturate each written result to 2^DATA_W-1 instead of truncating.
module single_pe_module #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mat_in_11, mat_in_12, mat_in_13, mat_in_14,
  input  logic [DATA_W-1:0] mat_in_21, mat_in_22, mat_in_23, mat_in_24,
  input  logic [DATA_W-1:0] mat_in_31, mat_in_32, mat_in_33, mat_in_34,
  input  logic [DATA_W-1:0] mat_in_41, mat_in_42, mat_in_43, mat_in_44,
  input  logic [DATA_W-1:0] kernel_11, kernel_12, kernel_13,
  input  logic [DATA_W-1:0] kernel_21, kernel_22, kernel_23,
  input  logic [DATA_W-1:0] kernel_31, kernel_32, kernel_33,
  output logic [DATA_W-1:0] conv_out_11,
  output logic [DATA_W-1:0] conv_out_12,
  output logic [DATA_W-1:0] conv_out_21,
  output logic [DATA_W-1:0] conv_out_22,
  output logic              done_single
);

  typedef enum logic [1:0] {LOAD, MAC, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mat_in [16];
  logic [DATA_W-1:0] ker_in [9];
  logic [DATA_W-1:0] mat_q  [16];
  logic [DATA_W-1:0] ker_q  [9];

  // Window index: bit 1 selects the row offset, bit 0 the column offset.
  logic [1:0]          win;
  logic [1:0]          k_row, k_col;
  logic [1:0]          m_row, m_col;
  logic [3:0]          ker_idx;
  logic                first_step, last_step;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc, sum;
  logic [DATA_W-1:0]   res;

  assign mat_in = '{mat_in_11, mat_in_12, mat_in_13, mat_in_14,
                    mat_in_21, mat_in_22, mat_in_23, mat_in_24,
                    mat_in_31, mat_in_32, mat_in_33, mat_in_34,
                    mat_in_41, mat_in_42, mat_in_43, mat_in_44};
  assign ker_in = '{kernel_11, kernel_12, kernel_13,
                    kernel_21, kernel_22, kernel_23,
                    kernel_31, kernel_32, kernel_33};

  assign m_row      = k_row + {1'b0, win[1]};
  assign m_col      = k_col + {1'b0, win[0]};
  assign ker_idx    = 4'(k_row) * 4'd3 + 4'(k_col);
  assign first_step = (k_row == 2'd0) && (k_col == 2'd0);
  assign last_step  = (k_row == 2'd2) && (k_col == 2'd2);
  assign prod       = mat_q[{m_row, m_col}] * ker_q[ker_idx];

  // NOTE: every variable written in always_comb gets a default first so no latch can be inferred.
  always_comb begin
    sum = ACC_W'(prod);
    if (!first_step) sum = acc + ACC_W'(prod);
`ifdef CONV_SAT_EN
    res = (|sum[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
    res = sum[DATA_W-1:0];
`endif
  end

  // NOTE: operand capture registers carry no reset; LOAD always overwrites them before first use.
  always_ff @(posedge clk) begin
    if (rst && state == LOAD) begin
      mat_q <= mat_in;
      ker_q <= ker_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= LOAD;
      win         <= '0;
      k_row       <= '0;
      k_col       <= '0;
      acc         <= '0;
      conv_out_11 <= '0;
      conv_out_12 <= '0;
      conv_out_21 <= '0;
      conv_out_22 <= '0;
      done_single <= 1'b0;
    end else begin
      case (state)
        LOAD: state <= MAC;
        MAC: begin
          acc <= sum;
          if (last_step) begin
            case (win)
              2'd0:    conv_out_11 <= res;
              2'd1:    conv_out_12 <= res;
              2'd2:    conv_out_21 <= res;
              default: conv_out_22 <= res;
            endcase
            k_row <= '0;
            k_col <= '0;
            if (win == 2'd3) begin
              state       <= DONE;
              done_single <= 1'b1;
            end else begin
              win <= win + 2'd1;
            end
          end else if (k_col == 2'd2) begin
            k_col <= '0;
            k_row <= k_row + 2'd1;
          end else begin
            k_col <= k_col + 2'd1;
          end
        end
        DONE:    state <= DONE;
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_single_pe_module.sv
// Directed bench for single_pe_module: vector table with per-edge output schedule plus reset/capture sequences.
module tb_single_pe_module;

  typedef struct packed {
    logic [0:15][7:0] mat;
    logic [0:8][7:0]  ker;
    logic [0:3][7:0]  exp;
  } vec_t;

`ifdef CONV_SAT_EN
  localparam logic [7:0] OVF_EXP = 8'd255;
`else
  localparam logic [7:0] OVF_EXP = 8'd9;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] mat [16];
  logic [7:0] ker [9];
  logic [7:0] c11, c12, c21, c22;
  logic       done;
  int         checks = 0;
  int         errors = 0;
  vec_t       tbl [4];

  always #5 clk = ~clk;

  single_pe_module dut (
    .clk(clk), .rst(rst),
    .mat_in_11(mat[0]),  .mat_in_12(mat[1]),  .mat_in_13(mat[2]),  .mat_in_14(mat[3]),
    .mat_in_21(mat[4]),  .mat_in_22(mat[5]),  .mat_in_23(mat[6]),  .mat_in_24(mat[7]),
    .mat_in_31(mat[8]),  .mat_in_32(mat[9]),  .mat_in_33(mat[10]), .mat_in_34(mat[11]),
    .mat_in_41(mat[12]), .mat_in_42(mat[13]), .mat_in_43(mat[14]), .mat_in_44(mat[15]),
    .kernel_11(ker[0]), .kernel_12(ker[1]), .kernel_13(ker[2]),
    .kernel_21(ker[3]), .kernel_22(ker[4]), .kernel_23(ker[5]),
    .kernel_31(ker[6]), .kernel_32(ker[7]), .kernel_33(ker[8]),
    .conv_out_11(c11), .conv_out_12(c12), .conv_out_21(c21), .conv_out_22(c22),
    .done_single(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] e11, input logic [7:0] e12,
                            input logic [7:0] e21, input logic [7:0] e22, input logic ed);
    check({tag, " conv_out_11"}, 32'(c11), 32'(e11));
    check({tag, " conv_out_12"}, 32'(c12), 32'(e12));
    check({tag, " conv_out_21"}, 32'(c21), 32'(e21));
    check({tag, " conv_out_22"}, 32'(c22), 32'(e22));
    check({tag, " done_single"}, 32'(done), 32'(ed));
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < 16; i++) mat[i] = v.mat[i];
    for (int i = 0; i < 9; i++) ker[i] = v.ker[i];
  endtask

  // One reset edge, then edges 1..37 checked against the result schedule, then 100 hold cycles.
  task automatic run_vec(input vec_t v, input bit zero_after_load, input string tag);
    load_vec(v);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int e = 1; e <= 37; e++) begin
      @(posedge clk); #1;
      if (zero_after_load && e == 5)
        for (int i = 0; i < 16; i++) mat[i] = 8'd0;
      check_outs($sformatf("%s edge%0d", tag, e),
                 (e >= 10) ? v.exp[0] : 8'd0, (e >= 19) ? v.exp[1] : 8'd0,
                 (e >= 28) ? v.exp[2] : 8'd0, (e >= 37) ? v.exp[3] : 8'd0, e >= 37);
    end
    for (int b = 0; b < 10; b++) begin
      repeat (10) @(posedge clk);
      #1;
      check_outs($sformatf("%s hold%0d", tag, b), v.exp[0], v.exp[1], v.exp[2], v.exp[3], 1'b1);
    end
  endtask

  initial begin
    tbl[0].mat = {8'd2, 8'd1, 8'd3, 8'd1,  8'd0, 8'd2, 8'd4, 8'd2,
                  8'd1, 8'd3, 8'd2, 8'd0,  8'd2, 8'd1, 8'd0, 8'd1};
    tbl[0].ker = {8'd1, 8'd0, 8'd1,  8'd1, 8'd1, 8'd0,  8'd0, 8'd1, 8'd1};
    tbl[0].exp = {8'd12, 8'd10, 8'd9, 8'd10};

    tbl[1].mat = {16{8'd255}};
    tbl[1].ker = {9{8'd255}};
    tbl[1].exp = {4{OVF_EXP}};

    tbl[2].mat = {8'd1, 8'd2, 8'd3, 8'd4,  8'd5, 8'd6, 8'd7, 8'd8,
                  8'd9, 8'd10, 8'd11, 8'd12,  8'd13, 8'd14, 8'd15, 8'd16};
    tbl[2].ker = {8'd0, 8'd0, 8'd0,  8'd0, 8'd1, 8'd0,  8'd0, 8'd0, 8'd0};
    tbl[2].exp = {8'd6, 8'd7, 8'd10, 8'd11};

    tbl[3].mat = tbl[2].mat;
    tbl[3].ker = {9{8'd1}};
    tbl[3].exp = {8'd54, 8'd63, 8'd90, 8'd99};

    // Held reset: outputs cleared regardless of inputs.
    load_vec(tbl[1]);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset_hold", 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);

    for (int v = 0; v < 4; v++) run_vec(tbl[v], 1'b0, $sformatf("vec%0d", v));

    // Mid-operation reset at edge 20, then a full rerun.
    load_vec(tbl[0]);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (19) @(posedge clk);
    #1;
    check_outs("pre_midreset", 8'd12, 8'd10, 8'd0, 8'd0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_outs("midreset", 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    run_vec(tbl[0], 1'b0, "after_midreset");

    // Inputs zeroed after LOAD must not disturb the results.
    run_vec(tbl[0], 1'b1, "capture");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
